// File: rtl/dmem_port_arbiter.sv
// Two-requester (pipeline P, DMA/debug D) arbiter for the single data-memory port.
// Optional feature: define DMEM_ARB_RR_EN for round-robin arbitration (default: fixed P over D).
module dmem_port_arbiter #(
    parameter int unsigned AW = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_req,
    input  logic [1:0]  p_we,
    input  logic [31:0] p_addr,
    input  logic [31:0] p_wdata,
    output logic        p_gnt,
    output logic        p_stall,
    input  logic        d_req,
    input  logic [1:0]  d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        rsel,
    output logic        err,
    output logic [1:0]  mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_P = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_p_elig;
    logic        w_d_elig;
    logic        w_pick_p;
    logic        w_grant;
    logic        w_reject;
    logic [1:0]  w_we;

    // Only stores carry an alignment constraint; reads fetch the whole word and
    // byte/half extraction happens downstream.
    function automatic logic f_reject(input logic [1:0] we, input logic [31:0] addr);
        logic w_range;
        logic w_align;
        w_range = |(addr >> AW);
        w_align = ((we == 2'b01) && (addr[1:0] != 2'b00)) ||
                  ((we == 2'b10) && addr[0]);
        return w_range || w_align;
    endfunction

    // The requester served this cycle sits out the next evaluation.
    assign w_p_elig = p_req && (r_state != GNT_P);
    assign w_d_elig = d_req && (r_state != GNT_D);

`ifdef DMEM_ARB_RR_EN
    logic r_last_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_d <= 1'b1;
        end else if (r_state == GNT_P) begin
            r_last_d <= 1'b0;
        end else if (r_state == GNT_D) begin
            r_last_d <= 1'b1;
        end
    end

    assign w_pick_p = w_p_elig && (!w_d_elig || r_last_d);
`else
    assign w_pick_p = w_p_elig;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = IDLE;
        if (w_pick_p) begin
            w_next = GNT_P;
        end else if (w_d_elig) begin
            w_next = GNT_D;
        end
    end

    always_comb begin
        w_we     = 2'b00;
        mem_a    = '0;
        mem_wd   = '0;
        w_reject = 1'b0;
        case (r_state)
            GNT_P: begin
                w_we     = p_we;
                mem_a    = p_addr;
                mem_wd   = p_wdata;
                w_reject = f_reject(p_we, p_addr);
            end
            GNT_D: begin
                w_we     = d_we;
                mem_a    = d_addr;
                mem_wd   = d_wdata;
                w_reject = f_reject(d_we, d_addr);
            end
            default: ;
        endcase
    end

    assign mem_we  = w_reject ? 2'b00 : w_we;
    assign p_gnt   = (r_state == GNT_P);
    assign d_gnt   = (r_state == GNT_D);
    assign p_stall = p_req && !p_gnt;
    assign w_grant = p_gnt || d_gnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid <= 1'b0;
            rsel   <= 1'b0;
            err    <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= w_grant;
            rsel   <= d_gnt;
            err    <= w_grant && w_reject;
            if (w_grant) begin
                rdata <= mem_rd;
            end
        end
    end

endmodule
